// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: control inputs, ROM address/data and the instruction stream to Control.
interface instr_fetch_if #(
  parameter int PC_W  = 10,
  parameter int IW    = 9,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Stall;
  logic             Branch;
  logic             BranchTaken;
  logic [PC_W-1:0]  Target;
  logic [IW-1:0]    ImemRdata;
  logic [PC_W-1:0]  ImemAddr;
  logic [IW-1:0]    Instr;
  logic             InstrValid;
  logic [PC_W-1:0]  PC;
  logic             Done;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Start, Stall, Branch, BranchTaken, Target, ImemRdata,
    output ImemAddr, Instr, InstrValid, PC, Done, InstrCount
  );
  modport slave (
    output Start, Stall, Branch, BranchTaken, Target, ImemRdata,
    input  ImemAddr, Instr, InstrValid, PC, Done, InstrCount
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: drives a 1-cycle-latency ROM, delivers one word per cycle,
// squashes one wrong-path word on a taken branch, supports stall and halt.
module instr_fetch #(
  parameter int PC_W  = 10,
  parameter int IW    = 9,
  parameter int CNT_W = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_e;

  state_e           state_q;
  logic [PC_W-1:0]  pc_q, fpc_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;

  logic run, halt_w, issue, taken, valid;

  assign run    = (state_q == RUN);
  // A halt word is only acted on once the stall releases.
  assign halt_w = run && !bus.Stall && (&bus.ImemRdata[IW-1:IW-5]);
  assign issue  = run && !bus.Stall && !halt_w;
  assign taken  = issue && bus.Branch && bus.BranchTaken;
  assign valid  = run && !halt_w;

  assign bus.ImemAddr   = (run && bus.Stall) ? pc_q : fpc_q;
  assign bus.InstrValid = valid;
  assign bus.Instr      = valid ? bus.ImemRdata : '0;
  assign bus.PC         = pc_q;
  assign bus.Done       = done_q;
  assign bus.InstrCount = cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fpc_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (issue && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: if (bus.Start) begin
          pc_q    <= '0;
          fpc_q   <= PC_W'(1);
          state_q <= RUN;
        end
        RUN: begin
          if (halt_w) begin
            done_q  <= 1'b1;
            fpc_q   <= '0;  // ROM presents mem[0] by the time a restart lands
            state_q <= HALT;
          end else if (taken) begin
            fpc_q   <= bus.Target;
            state_q <= FLUSH;
          end else if (issue) begin
            pc_q  <= fpc_q;
            fpc_q <= fpc_q + PC_W'(1);
          end
        end
        FLUSH: begin
          pc_q    <= fpc_q;
          fpc_q   <= fpc_q + PC_W'(1);
          state_q <= RUN;
        end
        HALT: if (bus.Start) begin
          done_q  <= 1'b0;
          pc_q    <= '0;
          fpc_q   <= PC_W'(1);
          cnt_q   <= '0;
          state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch plus a narrow-PC instance for wrap/saturation.
module tb_instr_fetch;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  instr_fetch_if #(.PC_W(10), .IW(9), .CNT_W(16)) b1 ();
  instr_fetch_if #(.PC_W(4),  .IW(9), .CNT_W(3))  b2 ();

  instr_fetch #(.PC_W(10), .IW(9), .CNT_W(16)) dut  (.Clk(Clk), .Reset(Reset), .bus(b1));
  instr_fetch #(.PC_W(4),  .IW(9), .CNT_W(3))  dut2 (.Clk(Clk), .Reset(Reset), .bus(b2));

  logic [8:0] mem  [1024];
  logic [8:0] mem2 [16];
  always @(posedge Clk) b1.ImemRdata <= mem[b1.ImemAddr];
  always @(posedge Clk) b2.ImemRdata <= mem2[b2.ImemAddr];

  typedef struct {
    logic start, stall, br, tk;
    logic [9:0] tgt;
    logic v; logic [8:0] instr; logic [9:0] pc; logic done; logic [15:0] cnt;
  } vec_t;

  vec_t tv[23];
  int pass = 0, total = 0;

  function automatic vec_t mk(input logic st, sl, b, t, input logic [9:0] tg,
                              input logic v, input logic [8:0] in, input logic [9:0] p,
                              input logic d, input logic [15:0] c);
    vec_t r;
    r.start = st; r.stall = sl; r.br = b; r.tk = t; r.tgt = tg;
    r.v = v; r.instr = in; r.pc = p; r.done = d; r.cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] obs1();
    return 64'({b1.InstrValid, b1.Instr, b1.PC, b1.Done, b1.InstrCount});
  endfunction

  task automatic drive(input logic st, sl, b, t, input logic [9:0] tg);
    b1.Start = st; b1.Stall = sl; b1.Branch = b; b1.BranchTaken = t; b1.Target = tg;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {1'b0, i[7:0]};
    mem[0] = 9'h010; mem[1] = 9'h020; mem[2] = 9'h030; mem[3] = 9'h1F0;
    for (int i = 0; i < 16; i++) mem2[i] = 9'(i);

    //          st sl br tk tgt      v  instr   pc     d  cnt
    tv[0]  = mk(0, 0, 0, 0, 10'h000, 0, 9'h000, 10'h000, 0, 0);
    tv[1]  = mk(1, 0, 0, 0, 10'h000, 0, 9'h000, 10'h000, 0, 0);
    tv[2]  = mk(0, 0, 0, 0, 10'h000, 1, 9'h010, 10'h000, 0, 0);
    tv[3]  = mk(0, 0, 0, 0, 10'h000, 1, 9'h020, 10'h001, 0, 1);
    tv[4]  = mk(0, 0, 0, 0, 10'h000, 1, 9'h030, 10'h002, 0, 2);
    tv[5]  = mk(0, 0, 1, 1, 10'h040, 0, 9'h000, 10'h003, 0, 3); // halt beats branch
    tv[6]  = mk(0, 0, 0, 0, 10'h000, 0, 9'h000, 10'h003, 1, 3);
    tv[7]  = mk(1, 0, 0, 0, 10'h000, 0, 9'h000, 10'h003, 1, 3);
    tv[8]  = mk(0, 0, 0, 0, 10'h000, 1, 9'h010, 10'h000, 0, 0);
    tv[9]  = mk(0, 0, 0, 0, 10'h000, 1, 9'h020, 10'h001, 0, 1);
    tv[10] = mk(0, 0, 1, 1, 10'h040, 1, 9'h030, 10'h002, 0, 2);
    tv[11] = mk(1, 1, 0, 0, 10'h000, 0, 9'h000, 10'h002, 0, 3); // flush ignores start/stall
    tv[12] = mk(0, 0, 0, 0, 10'h000, 1, 9'h040, 10'h040, 0, 3);
    tv[13] = mk(0, 0, 1, 1, 10'h005, 1, 9'h041, 10'h041, 0, 4);
    tv[14] = mk(0, 0, 0, 0, 10'h000, 0, 9'h000, 10'h041, 0, 5);
    tv[15] = mk(0, 1, 0, 0, 10'h000, 1, 9'h005, 10'h005, 0, 5);
    tv[16] = mk(0, 1, 0, 0, 10'h000, 1, 9'h005, 10'h005, 0, 5);
    tv[17] = mk(0, 1, 0, 0, 10'h000, 1, 9'h005, 10'h005, 0, 5);
    tv[18] = mk(0, 0, 0, 0, 10'h000, 1, 9'h005, 10'h005, 0, 5);
    tv[19] = mk(0, 0, 0, 0, 10'h000, 1, 9'h006, 10'h006, 0, 6);
    tv[20] = mk(0, 0, 1, 0, 10'h040, 1, 9'h007, 10'h007, 0, 7);
    tv[21] = mk(0, 0, 0, 0, 10'h000, 1, 9'h008, 10'h008, 0, 8);
    tv[22] = mk(0, 0, 0, 0, 10'h000, 1, 9'h009, 10'h009, 0, 9);

    drive(0, 0, 0, 0, 10'h000);
    b2.Start = 0; b2.Stall = 0; b2.Branch = 0; b2.BranchTaken = 0; b2.Target = '0;
    #1;
    chk("reset_state", obs1(), 64'({1'b0, 9'h000, 10'h000, 1'b0, 16'h0}));
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    foreach (tv[i]) begin
      @(negedge Clk);
      drive(tv[i].start, tv[i].stall, tv[i].br, tv[i].tk, tv[i].tgt);
      #1;
      chk($sformatf("vec%0d", i), obs1(),
          64'({tv[i].v, tv[i].instr, tv[i].pc, tv[i].done, tv[i].cnt}));
    end

    // Asynchronous reset mid-run, well away from any rising edge
    drive(0, 0, 0, 0, 10'h000);
    Reset = 1'b0;
    #1;
    chk("async_reset", obs1(), 64'({1'b0, 9'h000, 10'h000, 1'b0, 16'h0}));
    #1 Reset = 1'b1;
    @(negedge Clk); #1;
    chk("idle_after_reset", obs1(), 64'({1'b0, 9'h000, 10'h000, 1'b0, 16'h0}));
    @(negedge Clk); drive(1, 0, 0, 0, 10'h000); #1;
    chk("restart_start", obs1(), 64'({1'b0, 9'h000, 10'h000, 1'b0, 16'h0}));
    @(negedge Clk); drive(0, 0, 0, 0, 10'h000); #1;
    chk("restart_first", obs1(), 64'({1'b1, 9'h010, 10'h000, 1'b0, 16'h0}));

    // Narrow instance: PC wraps 15->0 with no bubble, count saturates at 7
    @(negedge Clk); b2.Start = 1'b1;
    @(negedge Clk); b2.Start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("wrap%0d", k),
          64'({b2.InstrValid, b2.Instr, b2.PC, b2.InstrCount}),
          64'({1'b1, 9'(k % 16), 4'(k % 16), 3'((k > 7) ? 7 : k)}));
      @(negedge Clk);
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
